// File: rtl/sc_regarb_pkg.sv
// Shared types for the register-bank arbiter.
// Op and FSM state encodings used by the top and its sub-block.
package sc_regarb_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    DONE   = 2'b10,
    CLRALL = 2'b11
  } state_t;

  function automatic logic is_clear_op(
    input logic [1:0] op
  );
    return |(op & OP_CLEAR);
  endfunction

endpackage

// File: rtl/sc_regarb_rrpick.sv
// Round-robin winner pick: first set request at or
// after the pointer, wrapping modulo N_REQ.
import sc_regarb_pkg::*;

module sc_regarb_rrpick #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    win,
  output logic             vld
);

  int k;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    win = '0;
    vld = 1'b0;
    k   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (req[k]) begin
        win = IW'(k);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_regbank_arbiter.sv
// Round-robin arbiter issuing single load/clear strobes
// into a shared register bank, with bank-wide clear.
import sc_regarb_pkg::*;

module sc_regbank_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int N_REQ     = 2,
  parameter int N_REG     = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                      SC_RegARB_CLOCK_50,
  input  logic                      SC_RegARB_RESET_InHigh,
  input  logic [N_REQ-1:0]          SC_RegARB_req_In,
  input  logic [2*N_REQ-1:0]        SC_RegARB_op_In,
  input  logic [N_REQ*ADDR_W-1:0]   SC_RegARB_addr_In,
  input  logic [N_REQ*DATAWIDTH-1:0] SC_RegARB_data_InBUS,
  input  logic                      SC_RegARB_clearall_In,
  output logic [N_REG-1:0]          SC_RegARB_load_OutBUS,
  output logic [N_REG-1:0]          SC_RegARB_clear_OutBUS,
  output logic [DATAWIDTH-1:0]      SC_RegARB_data_OutBUS,
  output logic [N_REQ-1:0]          SC_RegARB_ack_Out,
  output logic                      SC_RegARB_err_Out,
  output logic                      SC_RegARB_busy_Out
);

  localparam int IW = $clog2(N_REQ);

  state_t          state;
  logic [IW-1:0]   rrPtr;
  logic [IW-1:0]   winQ;
  logic            badQ;

  logic [IW-1:0]   pickWin;
  logic            pickVld;

  logic [1:0]           selOp;
  logic [ADDR_W-1:0]    selAddr;
  logic [DATAWIDTH-1:0] selData;
  logic                 selOk;
  logic [N_REG-1:0]     selHot;

  sc_regarb_rrpick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req (SC_RegARB_req_In),
    .ptr (rrPtr),
    .win (pickWin),
    .vld (pickVld)
  );

  always_comb begin
    selOp   = SC_RegARB_op_In[2*int'(pickWin) +: 2];
    selAddr = SC_RegARB_addr_In[ADDR_W*int'(pickWin) +: ADDR_W];
    selData = SC_RegARB_data_InBUS[DATAWIDTH*int'(pickWin) +: DATAWIDTH];
    selOk   = int'(selAddr) < N_REG;
    selHot  = N_REG'(1) << selAddr;
  end

  // Strobes are registered at the latch edge so they
  // appear in the ISSUE cycle itself.
  always_ff @(posedge SC_RegARB_CLOCK_50) begin
    if (SC_RegARB_RESET_InHigh) begin
      state                  <= IDLE;
      rrPtr                  <= '0;
      winQ                   <= '0;
      badQ                   <= 1'b0;
      SC_RegARB_load_OutBUS  <= '0;
      SC_RegARB_clear_OutBUS <= '0;
      SC_RegARB_data_OutBUS  <= '0;
      SC_RegARB_ack_Out      <= '0;
      SC_RegARB_err_Out      <= 1'b0;
      SC_RegARB_busy_Out     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          SC_RegARB_load_OutBUS  <= '0;
          SC_RegARB_clear_OutBUS <= '0;
          SC_RegARB_data_OutBUS  <= '0;
          SC_RegARB_ack_Out      <= '0;
          SC_RegARB_err_Out      <= 1'b0;
          if (SC_RegARB_clearall_In) begin
            SC_RegARB_clear_OutBUS <= '1;
            SC_RegARB_busy_Out     <= 1'b1;
            state                  <= CLRALL;
          end else if (pickVld) begin
            winQ               <= pickWin;
            badQ               <= !selOk;
            SC_RegARB_busy_Out <= 1'b1;
            state              <= ISSUE;
            if (selOk && op_t'(selOp) == OP_LOAD) begin
              SC_RegARB_load_OutBUS <= selHot;
              SC_RegARB_data_OutBUS <= selData;
            end else if (selOk && is_clear_op(selOp)) begin
              SC_RegARB_clear_OutBUS <= selHot;
            end
          end
        end
        ISSUE: begin
          SC_RegARB_load_OutBUS  <= '0;
          SC_RegARB_clear_OutBUS <= '0;
          SC_RegARB_data_OutBUS  <= '0;
          SC_RegARB_ack_Out      <= N_REQ'(1) << winQ;
          SC_RegARB_err_Out      <= badQ;
          state                  <= DONE;
        end
        DONE: begin
          SC_RegARB_ack_Out  <= '0;
          SC_RegARB_err_Out  <= 1'b0;
          SC_RegARB_busy_Out <= 1'b0;
          if (int'(winQ) == N_REQ - 1) begin
            rrPtr <= '0;
          end else begin
            rrPtr <= winQ + 1'b1;
          end
          state <= IDLE;
        end
        CLRALL: begin
          SC_RegARB_clear_OutBUS <= '0;
          SC_RegARB_busy_Out     <= 1'b0;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
